id_register_file_mp: RTL and testbench

//  Parametrised multi-port MIPS register file for the ID stage with built-in WB->ID bypass.
//  N combinational read ports and M clocked write ports. R0 is hardwired to zero.
//  A pending-write scoreboard flags reads of registers still awaiting a long-latency result.

---
 rtl/id_register_file_mp.sv | 132 +++++++++++++
 tb/tb_id_register_file_mp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_register_file_mp.sv
// id_register_file_mp
//   Multi-port MIPS register file for the ID stage with WB->ID bypass and a
//   pending-write scoreboard for long-latency producers. R0 reads as zero.
//
//   Clk                clock; all state updates on posedge
//   Rst_n              asynchronous active-low reset
//   Read_Address_ID    NUM_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   Read_Data_ID       NUM_RD packed read data, combinational (bypassed)
//   Hazard_ID          per read port: register pending and not bypassed this cycle
//   RegWrite_WB        per write port enable
//   Write_Register_WB  NUM_WR packed write addresses
//   Write_Data_WB      NUM_WR packed write data
//   Pend_Set_EX        long-latency producer issued this cycle
//   Pend_Addr_EX       destination register of that producer
//   Pending_Count      registered number of set scoreboard bits
module id_register_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] Read_Address_ID,
  output logic [NUM_RD*DATA_W-1:0] Read_Data_ID,
  output logic [NUM_RD-1:0]        Hazard_ID,
  input  logic [NUM_WR-1:0]        RegWrite_WB,
  input  logic [NUM_WR*ADDR_W-1:0] Write_Register_WB,
  input  logic [NUM_WR*DATA_W-1:0] Write_Data_WB,
  input  logic                     Pend_Set_EX,
  input  logic [ADDR_W-1:0]        Pend_Addr_EX,
  output logic [CNT_W-1:0]         Pending_Count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [CNT_W-1:0]  r_pend_cnt;

  logic [DEPTH-1:0]  w_wr_en;
  logic [DATA_W-1:0] w_wr_data [DEPTH];
  logic [DEPTH-1:0]  w_pend_next;
  logic [CNT_W-1:0]  w_pend_cnt_next;

  // Per-register write decode; ascending port order lets the highest enabled port win.
  always_comb begin
    w_wr_en = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      w_wr_data[r] = '0;
    end
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (RegWrite_WB[w] && (Write_Register_WB[w*ADDR_W +: ADDR_W] != '0)) begin
        w_wr_en[Write_Register_WB[w*ADDR_W +: ADDR_W]]   = 1'b1;
        w_wr_data[Write_Register_WB[w*ADDR_W +: ADDR_W]] = Write_Data_WB[w*DATA_W +: DATA_W];
      end
    end
  end

  // Register array; entry 0 is never written so it stays zero.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (w_wr_en[r]) begin
          r_regs[r] <= w_wr_data[r];
        end
      end
    end
  end

  // Scoreboard next state: retiring writes clear, a new producer sets (set applied last so it wins).
  always_comb begin
    w_pend_next = r_pend & ~w_wr_en;
    if (Pend_Set_EX && (Pend_Addr_EX != '0)) begin
      w_pend_next[Pend_Addr_EX] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  // Popcount of the next scoreboard so the registered count tracks the registered bits.
  always_comb begin
    w_pend_cnt_next = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      w_pend_cnt_next = w_pend_cnt_next + CNT_W'(w_pend_next[r]);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pend     <= w_pend_next;
      r_pend_cnt <= w_pend_cnt_next;
    end
  end

  assign Pending_Count = r_pend_cnt;

  // Read ports: R0 -> 0, else highest matching enabled write port, else stored value.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_hit;

    assign w_addr = Read_Address_ID[g*ADDR_W +: ADDR_W];

    always_comb begin
      w_hit  = 1'b0;
      w_data = r_regs[w_addr];
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (RegWrite_WB[w] && (Write_Register_WB[w*ADDR_W +: ADDR_W] == w_addr)) begin
          w_hit  = 1'b1;
          w_data = Write_Data_WB[w*DATA_W +: DATA_W];
        end
      end
      if (w_addr == '0) begin
        w_hit  = 1'b0;
        w_data = '0;
      end
    end

    assign Read_Data_ID[g*DATA_W +: DATA_W] = w_data;
    assign Hazard_ID[g] = r_pend[w_addr] & ~w_hit & (w_addr != '0);
  end

endmodule

// File: tb/tb_id_register_file_mp.sv
// tb_id_register_file_mp
//   Directed bench for id_register_file_mp with two write ports: reset, write/read,
//   R0, bypass, write-port priority, scoreboard set/clear/count and async reset.
module tb_id_register_file_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned CNT_W  = 6;

  logic                     Clk;
  logic                     Rst_n;
  logic [NUM_RD*ADDR_W-1:0] Read_Address_ID;
  logic [NUM_RD*DATA_W-1:0] Read_Data_ID;
  logic [NUM_RD-1:0]        Hazard_ID;
  logic [NUM_WR-1:0]        RegWrite_WB;
  logic [NUM_WR*ADDR_W-1:0] Write_Register_WB;
  logic [NUM_WR*DATA_W-1:0] Write_Data_WB;
  logic                     Pend_Set_EX;
  logic [ADDR_W-1:0]        Pend_Addr_EX;
  logic [CNT_W-1:0]         Pending_Count;

  int n_checks = 0;
  int n_fails  = 0;

  id_register_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Read_Address_ID(Read_Address_ID),
    .Read_Data_ID(Read_Data_ID),
    .Hazard_ID(Hazard_ID),
    .RegWrite_WB(RegWrite_WB),
    .Write_Register_WB(Write_Register_WB),
    .Write_Data_WB(Write_Data_WB),
    .Pend_Set_EX(Pend_Set_EX),
    .Pend_Addr_EX(Pend_Addr_EX),
    .Pending_Count(Pending_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_wr(input int p, input logic en, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    RegWrite_WB[p]                      = en;
    Write_Register_WB[p*ADDR_W +: ADDR_W] = a;
    Write_Data_WB[p*DATA_W +: DATA_W]     = d;
  endtask

  task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
    Read_Address_ID[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle_inputs();
    RegWrite_WB       = '0;
    Write_Register_WB = '0;
    Write_Data_WB     = '0;
    Pend_Set_EX       = 1'b0;
    Pend_Addr_EX      = '0;
  endtask

  function automatic logic [DATA_W-1:0] rd(input int p);
    return Read_Data_ID[p*DATA_W +: DATA_W];
  endfunction

  // Apply the current inputs across one rising edge, then return mid-low phase.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Rst_n = 1'b0;
    Read_Address_ID = '0;
    idle_inputs();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Reset state
    set_rd(0, 5'd5); set_rd(1, 5'd31);
    #1;
    check_eq("rst_rd0", 64'(rd(0)), 64'h0);
    check_eq("rst_rd1", 64'(rd(1)), 64'h0);
    check_eq("rst_haz", 64'(Hazard_ID), 64'h0);
    check_eq("rst_cnt", 64'(Pending_Count), 64'h0);

    // Write R5 then read on both ports
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    idle_inputs();
    set_rd(0, 5'd5); set_rd(1, 5'd5);
    #1;
    check_eq("r5_p0", 64'(rd(0)), 64'hDEADBEEF);
    check_eq("r5_p1", 64'(rd(1)), 64'hDEADBEEF);

    // Write to R0 is neither bypassed nor stored
    set_wr(0, 1'b1, 5'd0, 32'h1234);
    set_rd(0, 5'd0);
    #1;
    check_eq("r0_bypass", 64'(rd(0)), 64'h0);
    step();
    idle_inputs();
    #1;
    check_eq("r0_stored", 64'(rd(0)), 64'h0);

    // Bypass: old value visible, then the in-flight write value
    set_wr(1, 1'b1, 5'd7, 32'h11111111);
    step();
    idle_inputs();
    set_rd(0, 5'd5); set_rd(1, 5'd7);
    #1;
    check_eq("r7_old", 64'(rd(1)), 64'h11111111);
    set_wr(0, 1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
    check_eq("r7_bypass", 64'(rd(1)), 64'hA5A5A5A5);
    check_eq("r5_unaff", 64'(rd(0)), 64'hDEADBEEF);
    step();
    idle_inputs();
    #1;
    check_eq("r7_stored", 64'(rd(1)), 64'hA5A5A5A5);

    // Two ports to the same register: higher index wins for bypass and store
    set_wr(0, 1'b1, 5'd9, 32'h1);
    set_wr(1, 1'b1, 5'd9, 32'h2);
    set_rd(0, 5'd9);
    #1;
    check_eq("r9_bypass", 64'(rd(0)), 64'h2);
    step();
    idle_inputs();
    #1;
    check_eq("r9_stored", 64'(rd(0)), 64'h2);

    // Two ports to different registers both land
    set_wr(0, 1'b1, 5'd10, 32'h10);
    set_wr(1, 1'b1, 5'd11, 32'h11);
    step();
    idle_inputs();
    set_rd(0, 5'd10); set_rd(1, 5'd11);
    #1;
    check_eq("r10", 64'(rd(0)), 64'h10);
    check_eq("r11", 64'(rd(1)), 64'h11);

    // Scoreboard: set R3
    set_rd(0, 5'd3); set_rd(1, 5'd5);
    Pend_Set_EX = 1'b1; Pend_Addr_EX = 5'd3;
    #1;
    check_eq("haz_pre_set", 64'(Hazard_ID), 64'h0);
    step();
    idle_inputs();
    #1;
    check_eq("cnt_set_r3", 64'(Pending_Count), 64'd1);
    check_eq("haz_r3", 64'(Hazard_ID), 64'b01);
    // WB retires R3: bypass hides the hazard in the same cycle
    set_wr(1, 1'b1, 5'd3, 32'h55);
    #1;
    check_eq("haz_r3_byp", 64'(Hazard_ID), 64'h0);
    check_eq("r3_byp", 64'(rd(0)), 64'h55);
    check_eq("cnt_before_clr", 64'(Pending_Count), 64'd1);
    step();
    idle_inputs();
    #1;
    check_eq("cnt_clr_r3", 64'(Pending_Count), 64'd0);
    check_eq("haz_r3_clr", 64'(Hazard_ID), 64'h0);
    check_eq("r3_stored", 64'(rd(0)), 64'h55);

    // Set R4, then set and retire R4 together: set wins
    Pend_Set_EX = 1'b1; Pend_Addr_EX = 5'd4;
    step();
    idle_inputs();
    #1;
    check_eq("cnt_r4", 64'(Pending_Count), 64'd1);
    Pend_Set_EX = 1'b1; Pend_Addr_EX = 5'd4;
    set_wr(0, 1'b1, 5'd4, 32'h44);
    step();
    idle_inputs();
    set_rd(0, 5'd4);
    #1;
    check_eq("cnt_setclr", 64'(Pending_Count), 64'd1);
    check_eq("haz_r4", 64'(Hazard_ID), 64'b01);
    check_eq("r4_stored", 64'(rd(0)), 64'h44);

    // Set on R0 ignored; re-set on already pending R4 leaves count alone
    Pend_Set_EX = 1'b1; Pend_Addr_EX = 5'd0;
    set_rd(1, 5'd0);
    step();
    idle_inputs();
    #1;
    check_eq("cnt_r0", 64'(Pending_Count), 64'd1);
    check_eq("haz_r0", 64'(Hazard_ID), 64'b01);
    Pend_Set_EX = 1'b1; Pend_Addr_EX = 5'd4;
    step();
    idle_inputs();
    #1;
    check_eq("cnt_reset_r4", 64'(Pending_Count), 64'd1);

    // Second pending register
    Pend_Set_EX = 1'b1; Pend_Addr_EX = 5'd6;
    step();
    idle_inputs();
    set_rd(1, 5'd6);
    #1;
    check_eq("cnt_r6", 64'(Pending_Count), 64'd2);
    check_eq("haz_r4_r6", 64'(Hazard_ID), 64'b11);

    // Asynchronous reset mid low phase
    set_rd(0, 5'd5); set_rd(1, 5'd4);
    #2;
    Rst_n = 1'b0;
    #1;
    check_eq("arst_rd0", 64'(rd(0)), 64'h0);
    check_eq("arst_haz", 64'(Hazard_ID), 64'h0);
    check_eq("arst_cnt", 64'(Pending_Count), 64'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    set_rd(1, 5'd7);
    #1;
    check_eq("arst_r7", 64'(rd(1)), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
